// File: rtl/hack_screen_pkg.sv
// ---------------------------------------------------------------------------
// hack_screen_pkg
// Shared constants and types for the monochrome screen scan-out path.
//   SCREEN_ROW_WORDS : 16-bit words per screen row (512 pixels)
//   SCREEN_ROWS      : rows per frame
//   SCREEN_WORDS     : words per frame (power of two, so addresses wrap)
//   scan_state_t     : scan-out controller states
// ---------------------------------------------------------------------------
package hack_screen_pkg;

  localparam int SCREEN_ROW_WORDS = 32;
  localparam int SCREEN_ROWS      = 256;
  localparam int SCREEN_WORDS     = SCREEN_ROW_WORDS * SCREEN_ROWS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } scan_state_t;

endpackage

// File: rtl/screen_shift16.sv
// ---------------------------------------------------------------------------
// screen_shift16
// 16-bit pixel shift register with its bit counter. Bit 0 is the pixel on
// offer; each shift moves the next (further right) pixel into bit 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture din and restart the bit count (wins over shift)
//   shift      : shift right by one and advance the bit count
//   din        : screen word to capture
//   dout       : current pixel (register bit 0)
//   bit_cnt    : index of the current pixel within the word
//   last       : current pixel is bit 15 of the word
// ---------------------------------------------------------------------------
module screen_shift16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        shift,
  input  logic [15:0] din,
  output logic        dout,
  output logic [3:0]  bit_cnt,
  output logic        last
);

  logic [15:0] shreg_r;
  logic [3:0]  cnt_r;

  // Load / shift register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= 16'h0000;
      cnt_r   <= 4'd0;
    end else if (load) begin
      shreg_r <= din;
      cnt_r   <= 4'd0;
    end else if (shift) begin
      shreg_r <= {1'b0, shreg_r[15:1]};
      cnt_r   <= cnt_r + 4'd1;
    end else begin
      shreg_r <= shreg_r;
      cnt_r   <= cnt_r;
    end
  end

  assign dout    = shreg_r[0];
  assign bit_cnt = cnt_r;
  assign last    = (cnt_r == 4'd15);

endmodule

// File: rtl/screen_scanout.sv
// ---------------------------------------------------------------------------
// screen_scanout
// Reads a bit-mapped screen from an asynchronous-read RAM and streams it as
// one pixel per valid/ready transfer, word bit 0 leftmost, frames back to
// back while enable is held.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : keep scanning frames (sampled in IDLE and at frame end)
//   ram_address : word address to the screen RAM (next word, prefetched)
//   ram_data    : screen RAM word at ram_address, same cycle
//   pix_valid   : pixel on offer
//   pix_ready   : downstream takes the pixel
//   pix_data    : pixel value, 1 = black
//   pix_sof     : pixel is row 0 column 0
//   pix_eol     : pixel is the last column of a row
//   frame_done  : one-cycle pulse after the last pixel of a frame is taken
// ---------------------------------------------------------------------------
module screen_scanout
  import hack_screen_pkg::*;
#(
  parameter int ROW_WORDS = SCREEN_ROW_WORDS,
  parameter int ROWS      = SCREEN_ROWS,
  localparam int WORDS    = ROW_WORDS * ROWS,
  localparam int AW       = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  output logic [AW-1:0] ram_address,
  input  logic [15:0]   ram_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_data,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          frame_done
);

  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(WORDS - 1);

  scan_state_t   state_r;
  logic [AW-1:0] addr_r;      // prefetch address driven to the RAM
  logic [AW-1:0] cur_addr_r;  // address of the word being shifted out
  logic          valid_r;
  logic          sof_r;
  logic          eol_r;
  logic          done_r;

  logic          load_s;
  logic          shift_s;
  logic          xfer_s;
  logic          last_s;
  logic          last_word_s;
  logic          col_last_s;
  logic          frame_end_s;
  logic [3:0]    bit_cnt_s;

  screen_shift16 u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_s),
    .shift   (shift_s),
    .din     (ram_data),
    .dout    (pix_data),
    .bit_cnt (bit_cnt_s),
    .last    (last_s)
  );

  assign xfer_s      = valid_r & pix_ready;
  assign last_word_s = (cur_addr_r == ADDR_LAST);
  assign col_last_s  = ((32'(cur_addr_r) % ROW_WORDS) == (ROW_WORDS - 1));
  assign frame_end_s = xfer_s & last_s & last_word_s;

  // Shift-register control: reload on the last bit of a word unless the
  // frame ends with enable low, otherwise shift on every transfer.
  always_comb begin
    load_s  = 1'b0;
    shift_s = 1'b0;
    case (state_r)
      IDLE: begin
        load_s  = 1'b0;
        shift_s = 1'b0;
      end
      LOAD: begin
        load_s = 1'b1;
      end
      SHIFT: begin
        if (xfer_s) begin
          if (last_s && (!last_word_s || enable)) begin
            load_s = 1'b1;
          end else begin
            shift_s = 1'b1;
          end
        end else begin
          load_s  = 1'b0;
          shift_s = 1'b0;
        end
      end
      default: begin
        load_s  = 1'b0;
        shift_s = 1'b0;
      end
    endcase
  end

  // Scan FSM, address counters and registered pixel flags. The sof/eol
  // flags are computed for the pixel that becomes current after the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      addr_r     <= ADDR_ZERO;
      cur_addr_r <= ADDR_ZERO;
      valid_r    <= 1'b0;
      sof_r      <= 1'b0;
      eol_r      <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          valid_r <= 1'b0;
          sof_r   <= 1'b0;
          eol_r   <= 1'b0;
          addr_r  <= ADDR_ZERO;
          if (enable) begin
            state_r <= LOAD;
          end
        end
        LOAD: begin
          state_r    <= SHIFT;
          valid_r    <= 1'b1;
          cur_addr_r <= addr_r;
          addr_r     <= addr_r + ADDR_ONE;
          sof_r      <= (addr_r == ADDR_ZERO);
          eol_r      <= 1'b0;
        end
        SHIFT: begin
          if (xfer_s) begin
            done_r <= frame_end_s;
            if (load_s) begin
              // Next word (or word 0 of the next frame) with no bubble;
              // addr_r has already wrapped to 0 after the last word.
              cur_addr_r <= addr_r;
              addr_r     <= addr_r + ADDR_ONE;
              sof_r      <= (addr_r == ADDR_ZERO);
              eol_r      <= 1'b0;
            end else if (frame_end_s) begin
              state_r <= IDLE;
              valid_r <= 1'b0;
              sof_r   <= 1'b0;
              eol_r   <= 1'b0;
              addr_r  <= ADDR_ZERO;
            end else begin
              sof_r <= 1'b0;
              eol_r <= (bit_cnt_s == 4'd14) && col_last_s;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          sof_r   <= 1'b0;
          eol_r   <= 1'b0;
          addr_r  <= ADDR_ZERO;
        end
      endcase
    end
  end

  assign ram_address = addr_r;
  assign pix_valid   = valid_r;
  assign pix_sof     = sof_r;
  assign pix_eol     = eol_r;
  assign frame_done  = done_r;

endmodule

// File: tb/tb_screen_scanout.sv
// ---------------------------------------------------------------------------
// tb_screen_scanout
// Directed bench for screen_scanout on a reduced 2x4-word screen
// (128 pixels per frame, 32 pixels per row) with a small RAM model.
// ---------------------------------------------------------------------------
module tb_screen_scanout;

  localparam int RW     = 2;
  localparam int RS     = 4;
  localparam int NW     = RW * RS;
  localparam int FPIX   = NW * 16;
  localparam int ROWPIX = RW * 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  ram_address;
  logic [15:0] ram_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        frame_done;

  logic [15:0] mem [0:NW-1];

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;
  int done_cnt = 0;
  int exp_idx  = 0;
  int xfer_cnt = 0;
  int eol_cnt  = 0;

  always #5 clk = ~clk;

  assign ram_data = mem[ram_address];

  screen_scanout #(.ROW_WORDS(RW), .ROWS(RS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol),
    .frame_done  (frame_done)
  );

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input int p);
    logic [15:0] w;
    w = mem[p / 16];
    return w[p % 16];
  endfunction

  // Take n pixels, optionally with ready pattern 1,0,0,1, checking each
  // accepted pixel against the RAM image and stalled pixels for stability.
  task automatic consume(input int n, input bit stall);
    int got;
    int cyc;
    logic [3:0] pat;
    bit held;
    logic pd, ps, pe;
    got = 0; cyc = 0; pat = 4'b1001; held = 1'b0; pd = 1'b0; ps = 1'b0; pe = 1'b0;
    while (got < n && cyc < 4 * n + 20) begin
      pix_ready = stall ? pat[cyc % 4] : 1'b1;
      if (held) begin
        check("hold_valid", pix_valid, 1);
        check("hold_data", pix_data, pd);
        check("hold_sof", pix_sof, ps);
        check("hold_eol", pix_eol, pe);
      end
      if (pix_valid && pix_ready) begin
        check("pix_data", pix_data, exp_bit(exp_idx));
        check("pix_sof", pix_sof, exp_idx == 0);
        check("pix_eol", pix_eol, (exp_idx % ROWPIX) == ROWPIX - 1);
        xfer_cnt++;
        if (pix_eol) eol_cnt++;
        exp_idx = (exp_idx + 1) % FPIX;
        got++;
      end
      held = pix_valid && !pix_ready;
      pd = pix_data; ps = pix_sof; pe = pix_eol;
      @(negedge clk);
      cyc++;
    end
    check("consume_count", got, n);
  endtask

  initial begin
    int lat;
    int f_start;
    int dc;
    rst_n = 1'b0; enable = 1'b0; pix_ready = 1'b0;
    mem[0] = 16'h0005; mem[1] = 16'h8001; mem[2] = 16'hA5C3; mem[3] = 16'h0F0F;
    mem[4] = 16'hFFFF; mem[5] = 16'h1234; mem[6] = 16'h8000; mem[7] = 16'h7FFE;

    repeat (2) @(negedge clk);
    check("rst_valid", pix_valid, 0);
    check("rst_data", pix_data, 0);
    check("rst_sof", pix_sof, 0);
    check("rst_eol", pix_eol, 0);
    check("rst_done", frame_done, 0);
    check("rst_addr", ram_address, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_valid", pix_valid, 0);
    check("idle_addr", ram_address, 0);

    // Latency from enable to first pixel, then word 0 = 0005 hand values.
    pix_ready = 1'b1; enable = 1'b1; lat = 0;
    while (!pix_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 2);
    check("first_pix", pix_data, 1);
    check("first_sof", pix_sof, 1);
    consume(16, 1'b0);
    consume(16, 1'b1);
    consume(FPIX - 32, 1'b0);
    check("f1_done", frame_done, 1);
    check("f1_xfers", xfer_cnt, FPIX);
    check("f1_eols", eol_cnt, RS);
    check("b2b_valid", pix_valid, 1);
    check("b2b_sof", pix_sof, 1);

    // Second frame back to back; enable dropped partway must not truncate.
    xfer_cnt = 0; eol_cnt = 0; f_start = cyc_cnt;
    consume(40, 1'b0);
    enable = 1'b0;
    consume(FPIX - 40, 1'b0);
    check("f2_done", frame_done, 1);
    check("f2_cycles", cyc_cnt - f_start, FPIX);
    check("f2_valid_low", pix_valid, 0);
    check("f2_addr", ram_address, 0);
    check("f2_xfers", xfer_cnt, FPIX);
    check("f2_eols", eol_cnt, RS);
    repeat (3) @(negedge clk);
    check("idle2_valid", pix_valid, 0);
    check("idle2_addr", ram_address, 0);
    check("idle2_done", frame_done, 0);
    check("done_pulses", done_cnt, 2);

    // Reset in the middle of a frame.
    enable = 1'b1; exp_idx = 0;
    consume(70, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", pix_valid, 0);
    check("mid_rst_data", pix_data, 0);
    check("mid_rst_sof", pix_sof, 0);
    check("mid_rst_eol", pix_eol, 0);
    check("mid_rst_done", frame_done, 0);
    check("mid_rst_addr", ram_address, 0);
    dc = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; exp_idx = 0;
    consume(20, 1'b0);
    check("no_done_after_rst", done_cnt, dc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
